// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: result-class flag codes,
// FSM state encoding and the operand class reported by div_classify.
package div_pkg;

  localparam logic [2:0] FL_IDLE  = 3'b000;  // no result since reset
  localparam logic [2:0] FL_BUSY  = 3'b001;  // iterative division running
  localparam logic [2:0] FL_OK    = 3'b010;  // general result
  localparam logic [2:0] FL_DIV0  = 3'b011;
  localparam logic [2:0] FL_DIV1  = 3'b100;
  localparam logic [2:0] FL_POW2  = 3'b101;
  localparam logic [2:0] FL_EQ    = 3'b110;
  localparam logic [2:0] FL_SMALL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CL_DIV0  = 3'd0,
    CL_DIV1  = 3'd1,
    CL_POW2  = 3'd2,
    CL_SMALL = 3'd3,
    CL_EQ    = 3'd4,
    CL_GEN   = 3'd5
  } cls_t;

endpackage

// File: rtl/div_classify.sv
// Combinational operand classifier.
// Ports: inA (dividend), inB (divisor) -> cls (first matching operand class
// in priority order), k (index of the highest set bit of inB; equals log2(inB)
// when inB is a power of two).
module div_classify
  import div_pkg::*;
#(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int KW = $clog2(VW)
) (
  input  logic [DW-1:0] inA,
  input  logic [VW-1:0] inB,
  output cls_t          cls,
  output logic [KW-1:0] k
);

  logic pow2;

  // Priority encoder: the highest set bit wins because it is assigned last.
  always_comb begin
    k = '0;
    for (int i = 0; i < VW; i++) begin
      if (inB[i]) k = KW'(i);
    end
  end

  // Only meaningful for inB >= 2; zero and one are caught earlier.
  assign pow2 = ((inB & (inB - VW'(1))) == '0);

  always_comb begin
    if (inB == '0)             cls = CL_DIV0;
    else if (inB == VW'(1))    cls = CL_DIV1;
    else if (pow2)             cls = CL_POW2;
    else if (inA < DW'(inB))   cls = CL_SMALL;
    else if (inA == DW'(inB))  cls = CL_EQ;
    else                       cls = CL_GEN;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider with LOAD/BUSY/DONE handshake.
// Trivial operand classes resolve on the LOAD edge; the general case runs a
// restoring shift-subtract loop, one quotient bit per clock, DW clocks total.
// Ports: CLOCK, RESET (async, active high), LOAD, inA (dividend), inB
// (divisor) -> BUSY, DONE (one-cycle pulse), FLAG (result class), qnt, rem.
//
// state | meaning
// IDLE  | waiting for LOAD, last result held on outputs
// CALC  | iterating, one quotient bit per edge
// FIN   | DONE pulse cycle; LOAD here starts the next operation
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          LOAD,
  input  logic [DW-1:0] inA,
  input  logic [VW-1:0] inB,
  output logic          BUSY,
  output logic          DONE,
  output logic [2:0]    FLAG,
  output logic [DW-1:0] qnt,
  output logic [VW-1:0] rem
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int KW = $clog2(VW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW-1:0] b_reg;
  logic [VW-1:0] p_reg;   // partial remainder, always < b_reg
  logic [DW-1:0] q_reg;

  cls_t          cls;
  logic [KW-1:0] k;

  logic [VW:0]   t, diff;
  logic          ge;
  logic [VW-1:0] p_nxt;
  logic [DW-1:0] q_nxt;

  logic [DW-1:0] sp_q, mask;
  logic [VW-1:0] sp_r;
  logic [2:0]    sp_flag;

  div_classify #(.DW(DW), .VW(VW), .KW(KW)) u_classify (
    .inA (inA),
    .inB (inB),
    .cls (cls),
    .k   (k)
  );

  // Borrow out of the VW+1-bit subtract tells whether T >= divisor.
  assign t     = {p_reg, q_reg[DW-1]};
  assign diff  = t - {1'b0, b_reg};
  assign ge    = ~diff[VW];
  assign p_nxt = ge ? diff[VW-1:0] : t[VW-1:0];
  assign q_nxt = {q_reg[DW-2:0], ge};

  assign mask  = (DW'(1) << k) - DW'(1);

  always_comb begin
    sp_q    = '0;
    sp_r    = '0;
    sp_flag = FL_IDLE;
    case (cls)
      CL_DIV0: begin
        sp_q    = '1;
        sp_r    = '1;
        sp_flag = FL_DIV0;
      end
      CL_DIV1: begin
        sp_q    = inA;
        sp_flag = FL_DIV1;
      end
      CL_POW2: begin
        sp_q    = inA >> k;
        sp_r    = VW'(inA & mask);
        sp_flag = FL_POW2;
      end
      CL_SMALL: begin
        sp_r    = inA[VW-1:0];
        sp_flag = FL_SMALL;
      end
      CL_EQ: begin
        sp_q    = DW'(1);
        sp_flag = FL_EQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      b_reg <= '0;
      p_reg <= '0;
      q_reg <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      FLAG  <= FL_IDLE;
      qnt   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          DONE <= 1'b0;
          if (LOAD) begin
            b_reg <= inB;
            q_reg <= inA;
            p_reg <= '0;
            if (cls == CL_GEN) begin
              state <= ST_CALC;
              cnt   <= CW'(DW - 1);
              BUSY  <= 1'b1;
              FLAG  <= FL_BUSY;
            end else begin
              state <= ST_FIN;
              DONE  <= 1'b1;
              FLAG  <= sp_flag;
              qnt   <= sp_q;
              rem   <= sp_r;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          p_reg <= p_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= ST_FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            FLAG  <= FL_OK;
            qnt   <= q_nxt;
            rem   <= p_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
